// File: rtl/ifu_axi_fetch_if.sv
// Signal bundle of the instruction fetch unit: fetch request/response plus the AXI4-lite AR/R read path.
// master = the fetch unit itself; slave = the control FSM and memory side it talks to.
interface ifu_axi_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_pc;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_inst;
  logic              resp_err;
  logic              busy;
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic              arready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rready;

  modport master (
    input  req_valid, req_pc, arready, rvalid, rdata, rresp,
    output resp_valid, resp_inst, resp_err, busy, arvalid, araddr, rready
  );

  modport slave (
    output req_valid, req_pc, arready, rvalid, rdata, rresp,
    input  resp_valid, resp_inst, resp_err, busy, arvalid, araddr, rready
  );
endinterface

// File: rtl/ifu_axi_fetch.sv
// Single-outstanding instruction fetch over an AXI4-lite AR/R channel, with read timeout and late-beat drain.
// Optional IFU_MISALIGN_CHECK_EN: reject fetches with pc[1:0]!=0 without touching the bus.
module ifu_axi_fetch #(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] NOP_INST       = 32'h0000_0013
) (
  input logic             clock,
  input logic             reset_n,
  ifu_axi_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DRAIN
  } state_e;

`ifdef IFU_MISALIGN_CHECK_EN
  localparam bit MISALIGN_CHECK = 1'b1;
`else
  localparam bit MISALIGN_CHECK = 1'b0;
`endif

  localparam bit         TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_e            state_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [ADDR_W-1:0] pend_pc_q;
  logic              pending_q;
  logic [7:0]        cnt_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_inst_q;

  // A new bus transaction starts either from IDLE or straight out of DRAIN when a request is waiting.
  logic              launch;
  logic [ADDR_W-1:0] launch_pc;
  logic              launch_bad;
  logic              timeout_hit;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    launch    = 1'b0;
    launch_pc = bus.req_pc;
    case (state_q)
      S_IDLE:  launch = bus.req_valid;
      S_DRAIN: begin
        launch = bus.rvalid && (bus.req_valid || pending_q);
        if (!bus.req_valid) launch_pc = pend_pc_q;
      end
      default: launch = 1'b0;
    endcase
  end

  assign launch_bad  = MISALIGN_CHECK && (launch_pc[1:0] != 2'b00);
  assign timeout_hit = TIMEOUT_EN && ((cnt_q + 8'd1) == TIMEOUT_LIM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      araddr_q     <= '0;
      pend_pc_q    <= '0;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_inst_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments only; later assignments in this block deliberately override earlier ones.
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
        end
        S_ADDR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cnt_q     <= '0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bus.rvalid) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= (bus.rresp != 2'b00);
            resp_inst_q  <= (bus.rresp == 2'b00) ? bus.rdata : NOP_INST;
            rready_q     <= 1'b0;
            state_q      <= S_IDLE;
          end else if (timeout_hit) begin
            // rready stays high so the late beat is swallowed in DRAIN.
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_inst_q  <= NOP_INST;
            state_q      <= S_DRAIN;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DRAIN: begin
          if (bus.rvalid) begin
            rready_q  <= 1'b0;
            pending_q <= 1'b0;
            state_q   <= S_IDLE;
          end else if (bus.req_valid) begin
            pending_q <= 1'b1;
            pend_pc_q <= bus.req_pc;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (launch) begin
        if (launch_bad) begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_inst_q  <= NOP_INST;
          state_q      <= S_IDLE;
        end else begin
          araddr_q  <= {launch_pc[ADDR_W-1:2], 2'b00};
          arvalid_q <= 1'b1;
          state_q   <= S_ADDR;
        end
      end
    end
  end

  assign bus.arvalid    = arvalid_q;
  assign bus.araddr     = araddr_q;
  assign bus.rready     = rready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_inst  = resp_inst_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Scoreboard bench for ifu_axi_fetch: directed scenarios plus randomized fetches with random bus stalls,
// error responses, timeouts and requests issued while draining a late beat.
`timescale 1ns/1ps
module tb_ifu_axi_fetch;

  localparam int          TO  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  ifu_axi_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ifu_axi_fetch #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TO),
    .NOP_INST(NOP)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } resp_t;

  // One fetch as the memory side will play it out.
  typedef struct {
    logic [31:0] pc;
    int          ar_dly;
    int          r_dly;
    logic [1:0]  rresp;
    logic [31:0] data;
    int          n_drain;
    logic [31:0] dpc0;
    logic [31:0] dpc1;
  } plan_t;

  resp_t       exp_q[$];
  logic [31:0] addr_q[$];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at t=%0t: got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] rand_pc(input bit allow_mis);
    logic [31:0] pc;
    pc      = $urandom;
    pc[1:0] = 2'b00;
    if (allow_mis && $urandom_range(0, 5) == 0) pc[1:0] = 2'($urandom_range(1, 3));
    return pc;
  endfunction

  function automatic plan_t make_plan(input logic [31:0] pc);
    plan_t p;
    int    mx;
    p.pc     = pc;
    p.ar_dly = $urandom_range(0, 5);
    p.r_dly  = $urandom_range(0, TO + 3);
    p.rresp  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    p.data   = $urandom;
    p.dpc0   = rand_pc(1'b0);
    p.dpc1   = rand_pc(1'b0);
    mx = p.r_dly - TO;
    if (mx < 0) mx = 0;
    if (mx > 2) mx = 2;
    p.n_drain = $urandom_range(0, mx);
    return p;
  endfunction

  // Reference: what the control FSM must see for a fetch played out as described by the plan.
  function automatic resp_t model_resp(input plan_t p);
    resp_t r;
    if ((MIS_EN && p.pc[1:0] != 2'b00) || p.r_dly >= TO || p.rresp != 2'b00) begin
      r.err  = 1'b1;
      r.inst = NOP;
    end else begin
      r.err  = 1'b0;
      r.inst = p.data;
    end
    return r;
  endfunction

  // Called on a falling edge; returns on the next falling edge with the request pulse done.
  task automatic start_txn(input plan_t p);
    exp_q.push_back(model_resp(p));
    if (!(MIS_EN && p.pc[1:0] != 2'b00)) addr_q.push_back(align(p.pc));
    bus.req_valid = 1'b1;
    bus.req_pc    = p.pc;
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  // Entered 1ns after a falling edge with the DUT in ADDR; returns on a falling edge.
  task automatic serve(input plan_t first);
    plan_t       p;
    bit          more;
    bit          have_next;
    logic [31:0] nxt;
    p    = first;
    more = 1'b1;
    while (more) begin
      more      = 1'b0;
      have_next = 1'b0;
      nxt       = '0;
      check("ar_valid_up", bus.arvalid, 1'b1);
      check("ar_addr_now", bus.araddr, align(p.pc));
      check("busy_addr", bus.busy, 1'b1);
      repeat (p.ar_dly) @(negedge clock);
      bus.arready = 1'b1;
      @(negedge clock);
      bus.arready = 1'b0;
      #1;
      check("r_ready_up", bus.rready, 1'b1);
      for (int j = 0; j < p.r_dly; j++) begin
        bus.req_valid = 1'b0;
        if (j == TO && p.n_drain > 0) begin
          bus.req_valid = 1'b1;
          bus.req_pc    = p.dpc0;
          nxt           = p.dpc0;
          have_next     = 1'b1;
        end
        if (j == TO + 1 && p.n_drain > 1) begin
          bus.req_valid = 1'b1;
          bus.req_pc    = p.dpc1;
          nxt           = p.dpc1;
        end
        bus.rdata = $urandom;
        bus.rresp = 2'($urandom);
        #1;
        if (j == TO - 1) check("no_early_timeout", bus.resp_valid, 1'b0);
        if (j == TO) begin
          check("timeout_pulse", bus.resp_valid, 1'b1);
          check("busy_drain", bus.busy, 1'b1);
        end
        @(negedge clock);
      end
      bus.req_valid = 1'b0;
      bus.rvalid    = 1'b1;
      bus.rdata     = p.data;
      bus.rresp     = p.rresp;
      @(negedge clock);
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
      bus.rresp  = 2'b00;
      if (have_next) begin
        p = make_plan(nxt);
        exp_q.push_back(model_resp(p));
        addr_q.push_back(align(nxt));
        #1;
        more = 1'b1;
      end
    end
  endtask

  task automatic run_txn(input plan_t p);
    start_txn(p);
    #1;
    if (MIS_EN && p.pc[1:0] != 2'b00) begin
      check("mis_no_arvalid", bus.arvalid, 1'b0);
      check("mis_resp_valid", bus.resp_valid, 1'b1);
      check("mis_busy", bus.busy, 1'b0);
      @(negedge clock);
    end else begin
      serve(p);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_arvalid"}, bus.arvalid, 1'b0);
    check({tag, "_rready"}, bus.rready, 1'b0);
    check({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
    check({tag, "_resp_err"}, bus.resp_err, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_resp_inst"}, bus.resp_inst, 32'h0);
    check({tag, "_araddr"}, bus.araddr, 32'h0);
  endtask

  // Monitor: pops the scoreboard on every response and AR handshake, and polices AR stability.
  initial begin
    bit          ar_wait;
    logic [31:0] ar_hold;
    resp_t       e;
    ar_wait = 1'b0;
    ar_hold = '0;
    forever begin
      @(negedge clock);
      #3;
      if (!reset_n) begin
        ar_wait = 1'b0;
      end else begin
        if (ar_wait) begin
          check("ar_stable_valid", bus.arvalid, 1'b1);
          check("ar_stable_addr", bus.araddr, ar_hold);
        end
        if (bus.arvalid && bus.arready) begin
          if (addr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ar at t=%0t: got addr=%0h want no transaction", $time, bus.araddr);
          end else begin
            check("ar_addr", bus.araddr, addr_q.pop_front());
          end
        end
        ar_wait = bus.arvalid && !bus.arready;
        ar_hold = bus.araddr;
        if (bus.resp_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp at t=%0t: got inst=%0h err=%0b want no response",
                     $time, bus.resp_inst, bus.resp_err);
          end else begin
            e = exp_q.pop_front();
            check("resp_err", bus.resp_err, e.err);
            check("resp_inst", bus.resp_inst, e.inst);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog at t=%0t: got no end of test want finish", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    plan_t p;
    int    w;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_pc    = '0;
    bus.arready   = 1'b0;
    bus.rvalid    = 1'b0;
    bus.rdata     = '0;
    bus.rresp     = 2'b00;
    repeat (3) @(negedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Zero-wait fetch: arvalid in c1, response in c3.
    p = make_plan(32'h8000_0000);
    p.ar_dly = 0; p.r_dly = 0; p.rresp = 2'b00; p.data = 32'h0000_0513; p.n_drain = 0;
    start_txn(p);
    #1;
    check("t1_arvalid_c1", bus.arvalid, 1'b1);
    check("t1_araddr_c1", bus.araddr, 32'h8000_0000);
    check("t1_no_resp_c1", bus.resp_valid, 1'b0);
    serve(p);
    #1;
    check("t1_resp_c3", bus.resp_valid, 1'b1);
    check("t1_inst_c3", bus.resp_inst, 32'h0000_0513);
    check("t1_err_c3", bus.resp_err, 1'b0);
    check("t1_busy_c3", bus.busy, 1'b0);
    @(negedge clock);

    // Slow address and data phases.
    p = make_plan(32'h0000_1000);
    p.ar_dly = 5; p.r_dly = 3; p.rresp = 2'b00; p.n_drain = 0;
    run_txn(p);
    #1;
    check("t2_inst_hold", bus.resp_inst, p.data);
    @(negedge clock);

    // Bus error response.
    p = make_plan(32'h0000_2000);
    p.ar_dly = 1; p.r_dly = 1; p.rresp = 2'b10; p.data = 32'hDEAD_BEEF; p.n_drain = 0;
    run_txn(p);

    // Timeout, new request during DRAIN, then a request that overwrites it.
    p = make_plan(32'h8000_0000);
    p.ar_dly = 0; p.r_dly = 6; p.rresp = 2'b00; p.n_drain = 1; p.dpc0 = 32'h8000_0004;
    run_txn(p);
    p = make_plan(32'h0000_3000);
    p.ar_dly = 2; p.r_dly = TO + 3; p.n_drain = 2;
    run_txn(p);

    // Reset in DATA: everything clears at once, no stale response afterwards.
    p = make_plan(32'h0000_4000);
    start_txn(p);
    #1;
    bus.arready = 1'b1;
    @(negedge clock);
    bus.arready = 1'b0;
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    addr_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    p = make_plan(32'h0000_5000);
    p.r_dly = 1; p.rresp = 2'b00; p.n_drain = 0;
    run_txn(p);

    // Misaligned pc.
    p = make_plan(32'h8000_0002);
    p.r_dly = 0; p.rresp = 2'b00; p.n_drain = 0;
    run_txn(p);

    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      run_txn(make_plan(rand_pc(1'b1)));
    end

    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clock);
      w++;
    end
    check("exp_q_empty", exp_q.size(), 0);
    check("addr_q_empty", addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
